muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply–divide unit, the multi-cycle companion to the single-cycle ALU decode/execute path. It accepts an operation selected by the M-extension `funct3` encoding plus two XLEN-bit operands, computes one result bit per cycle, and returns the result over a valid/ready handshake. It sits in the execute stage beside the ALU; the pipeline stalls while `ready_o`/`valid_o` are low and flushes it with `kill_i`.

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one result bit per cycle, with a valid/ready result handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    input  logic            ready_i
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [XLEN-1:0]     bmag_q, bmag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed, in_sa, in_sb;
    logic signed [XLEN-1:0] a_sgn, b_sgn;
    logic [XLEN-1:0]     a_mag, b_mag, fast_res;
    logic                div0, ovf;
    logic [XLEN:0]       mul_sum, rem_sh;
    logic [XLEN-1:0]     div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   mul_next, div_next, step, prod;
    logic [XLEN-1:0]     final_res;

    always_comb begin
        a_sgn    = a_i;
        b_sgn    = b_i;
        a_signed = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
                   (funct3_i == F_DIV)  || (funct3_i == F_REM);
        b_signed = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
        in_sa    = a_signed && a_sgn[XLEN-1];
        in_sb    = b_signed && b_sgn[XLEN-1];
        a_mag    = cond_neg(a_i, in_sa);
        b_mag    = cond_neg(b_i, in_sb);

        // Division corner cases resolve without iterating
        div0 = funct3_i[2] && (b_i == '0);
        ovf  = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
               (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        fast_res = '0;
        if (div0) begin
            fast_res = funct3_i[1] ? a_i : '1;
        end else if (ovf) begin
            fast_res = funct3_i[1] ? '0 : a_i;
        end
    end

    always_comb begin
        // Multiply: accumulate into the upper half, retire multiplier bits from the bottom
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? bmag_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: remainder in the upper half, dividend shifts out as quotient shifts in
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = rem_sh >= {1'b0, bmag_q};
        div_diff = rem_sh[XLEN-1:0] - bmag_q;
        div_next = {(div_ge ? div_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        step = op_q[2] ? div_next : mul_next;
        prod = cond_neg2(step, sa_q ^ sb_q);

        case (op_q)
            F_MUL:                     final_res = prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: final_res = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             final_res = cond_neg(step[XLEN-1:0], sa_q ^ sb_q);
            default:                   final_res = cond_neg(step[2*XLEN-1:XLEN], sa_q);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bmag_d   = bmag_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && !kill_i) begin
                    op_d   = funct3_i;
                    sa_d   = in_sa;
                    sb_d   = in_sb;
                    bmag_d = b_mag;
                    if (div0 || ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        cnt_d   = CW'(XLEN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over accept, completion and consumption
        if (kill_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bmag_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bmag_q   <= bmag_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit at XLEN=32 against hand values
// and a behavioural reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic [31:0] result_o;
    logic        ready_i = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    // Present one request for exactly one edge; called 1 time unit after a posedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3_i = f;
        a_i      = a;
        b_i      = b;
        valid_i  = 1'b1;
        @(posedge clk); #1;
        valid_i  = 1'b0;
    endtask

    // Latency counts edges from the accept edge up to the one that raises valid_o.
    task automatic wait_valid(output int lat, output logic [31:0] res);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin sp = sa * sb; p = sp; return p[63:32]; end
            3'b010: begin sp = sa * longint'({32'b0, b}); p = sp; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                sp = sa / sb; p = sp; return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                sp = sa % sb; p = sp; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #12;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready_o=%b valid_o=%b result_o=%h, want 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  f[4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [31:0] a[4] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b[4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int lat;
        logic [31:0] res;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i]);
            wait_valid(lat, res);
            n_checks++;
            if (res !== e[i]) begin
                n_fail++;
                $display("FAIL mul_result[%0d]: got %h, want %h", i, res, e[i]);
            end
            n_checks++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL mul_latency[%0d]: got %0d, want 33", i, lat);
            end
            @(posedge clk); #1;
            n_checks++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_handshake[%0d]: ready_o=%b valid_o=%b, want 1 0", i, ready_o, valid_o);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f[5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110};
        logic [31:0] a[5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7, 32'h7};
        logic [31:0] b[5] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'hFFFFFFFE};
        logic [31:0] e[5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1, 32'h1};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            issue(f[i], a[i], b[i]);
            wait_valid(lat, res);
            n_checks++;
            if (res !== e[i] || lat !== 33) begin
                n_fail++;
                $display("FAIL div_result[%0d]: got %h lat %0d, want %h lat 33", i, res, lat, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  f[5] = '{3'b100, 3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] a[5] = '{32'h5, 32'h5, 32'h5, 32'h80000000, 32'h80000000};
        logic [31:0] b[5] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h80000000, 32'h0};
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            issue(f[i], a[i], b[i]);
            wait_valid(lat, res);
            n_checks++;
            if (res !== e[i] || lat !== 1) begin
                n_fail++;
                $display("FAIL fast_path[%0d]: got %h lat %0d, want %h lat 1", i, res, lat, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        ready_i = 1'b0;
        issue(3'b000, 32'd6, 32'd7);
        wait_valid(lat, res);
        n_checks++;
        if (res !== 32'd42) begin
            n_fail++;
            $display("FAIL bp_result: got %h, want 0000002a", res);
        end
        for (int i = 0; i < 5; i++) begin
            funct3_i = 3'b000; a_i = 32'd1; b_i = 32'd1; valid_i = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'd42) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid_o=%b ready_o=%b result_o=%h, want 1 0 0000002a",
                         i, valid_o, ready_o, result_o);
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: ready_o=%b valid_o=%b, want 1 0", ready_o, valid_o);
        end
        issue(3'b101, 32'd100, 32'd7);
        wait_valid(lat, res);
        n_checks++;
        if (res !== 32'd14 || lat !== 33) begin
            n_fail++;
            $display("FAIL bp_next_op: got %h lat %0d, want 0000000e lat 33", res, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        int lat;
        int seen;
        logic [31:0] res;
        issue(3'b100, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: ready_o=%b valid_o=%b, want 1 0", ready_o, valid_o);
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL kill_no_result: valid_o high %0d cycles, want 0", seen);
        end
        // request presented together with kill must be dropped
        funct3_i = 3'b000; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_drop: ready_o=%b, want 1", ready_o);
        end
        issue(3'b000, 32'd3, 32'd4);
        wait_valid(lat, res);
        n_checks++;
        if (res !== 32'd12 || lat !== 33) begin
            n_fail++;
            $display("FAIL kill_then_mul: got %h lat %0d, want 0000000c lat 33", res, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [31:0] res;
        issue(3'b111, 32'd99, 32'd10);
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ready_o=%b valid_o=%b result_o=%h, want 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (45) begin @(posedge clk); #1; if (valid_o) seen++; end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_result: valid_o high %0d cycles, want 0", seen);
        end
        issue(3'b111, 32'd99, 32'd10);
        wait_valid(lat, res);
        n_checks++;
        if (res !== 32'd9 || lat !== 33) begin
            n_fail++;
            $display("FAIL reset_then_op: got %h lat %0d, want 00000009 lat 33", res, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, exp, res;
        int lat, exp_lat, guard;
        logic rdy;
        for (int n = 0; n < 1200; n++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            ready_i = 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                issue(f, a, b);
                repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
                kill_i = 1'b1;
                @(posedge clk); #1;
                kill_i = 1'b0;
                n_checks++;
                if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_kill[%0d]: ready_o=%b valid_o=%b, want 1 0", n, ready_o, valid_o);
                end
            end else begin
                exp     = ref_model(f, a, b);
                exp_lat = ((f[2] && b == 0) ||
                           ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF))
                          ? 1 : 33;
                ready_i = 1'b0;
                issue(f, a, b);
                wait_valid(lat, res);
                n_checks++;
                if (res !== exp || lat !== exp_lat) begin
                    n_fail++;
                    $display("FAIL rnd_op[%0d]: f=%0d a=%h b=%h got %h lat %0d, want %h lat %0d",
                             n, f, a, b, res, lat, exp, exp_lat);
                end
                guard = 0;
                forever begin
                    rdy = 1'($urandom_range(0, 1));
                    ready_i = rdy;
                    @(posedge clk); #1;
                    if (rdy || guard > 20) break;
                    guard++;
                    n_checks++;
                    if (valid_o !== 1'b1 || result_o !== res) begin
                        n_fail++;
                        $display("FAIL rnd_hold[%0d]: valid_o=%b result_o=%h, want 1 %h",
                                 n, valid_o, result_o, res);
                    end
                end
                ready_i = 1'b1;
                if (valid_o) begin @(posedge clk); #1; end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
